// File: rtl/mac_pipe_if.sv
`timescale 1ns/1ps
// mac_pipe_if: stream bus for the pipelined MAC.
//   Upstream side : in_valid, a, b, first, last (product framing)
//   Result side   : out_valid, acc_out, sat_out, overflow
//   master modport = producer/consumer around the MAC, slave modport = mac_pipe.
interface mac_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     first;
  logic                     last;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  acc_out;
  logic signed [DATA_W-1:0] sat_out;
  logic                     overflow;

  modport master (
    output in_valid, a, b, first, last,
    input  out_valid, acc_out, sat_out, overflow
  );

  modport slave (
    input  in_valid, a, b, first, last,
    output out_valid, acc_out, sat_out, overflow
  );
endinterface

// File: rtl/mac_pipe.sv
`timescale 1ns/1ps
// mac_pipe: four-stage signed multiply-accumulate.
//   S1 registers operands, S2 registers the full product, S3 accumulates with
//   saturation, S4 registers the framed result. last at input cycle N gives a
//   one-cycle out_valid in cycle N+4.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mac_pipe_if.slave: in_valid/a/b/first/last in,
//          out_valid/acc_out/sat_out/overflow out
module mac_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  mac_pipe_if.slave  bus
);
  localparam int PROD_W = 2 * DATA_W;

  // Output clamp rails expressed at the ACC_W+1 working width.
  localparam logic signed [ACC_W:0] SAT_HI =
    {{(ACC_W+1-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO =
    {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  // Clamp an ACC_W+1 sum back to ACC_W; the two top bits differ on overflow.
  function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1]) begin
      clamp_acc = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      clamp_acc = v[ACC_W-1:0];
    end
  endfunction

  function automatic logic acc_clamped(input logic signed [ACC_W:0] v);
    acc_clamped = (v[ACC_W] != v[ACC_W-1]);
  endfunction

  // Clamp the rounded/shifted value to the DATA_W output range.
  function automatic logic signed [DATA_W-1:0] clamp_out(input logic signed [ACC_W:0] r);
    if (r > SAT_HI) begin
      clamp_out = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (r < SAT_LO) begin
      clamp_out = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      clamp_out = r[DATA_W-1:0];
    end
  endfunction

  logic                     s1_valid_r, s1_first_r, s1_last_r;
  logic signed [DATA_W-1:0] s1_a_r, s1_b_r;
  logic                     s2_valid_r, s2_first_r, s2_last_r;
  logic signed [PROD_W-1:0] s2_prod_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     ovf_r;
  logic                     s3_fire_r;
  logic                     out_valid_r, overflow_r;
  logic signed [ACC_W-1:0]  acc_out_r;
  logic signed [DATA_W-1:0] sat_out_r;

  logic signed [ACC_W:0]    prod_ext_s, sum_s, acc_ext_s, r_s;
  logic signed [ACC_W-1:0]  acc_nxt_s;
  logic                     ovf_nxt_s;

  // S1: operand and framing capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
    end else begin
      s1_valid_r <= bus.in_valid;
      s1_first_r <= bus.first;
      s1_last_r  <= bus.last;
      s1_a_r     <= bus.a;
      s1_b_r     <= bus.b;
    end
  end

  // S2: full-precision signed product.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_prod_r  <= '0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_first_r <= s1_first_r;
      s2_last_r  <= s1_last_r;
      s2_prod_r  <= PROD_W'(s1_a_r) * PROD_W'(s1_b_r);
    end
  end

  // Next accumulator: first restarts the sum, otherwise saturating add.
  always_comb begin
    prod_ext_s = {{(ACC_W+1-PROD_W){s2_prod_r[PROD_W-1]}}, s2_prod_r};
    sum_s      = {acc_r[ACC_W-1], acc_r} + prod_ext_s;
    acc_nxt_s  = acc_r;
    ovf_nxt_s  = ovf_r;
    if (s2_first_r) begin
      acc_nxt_s = prod_ext_s[ACC_W-1:0];
      ovf_nxt_s = 1'b0;
    end else begin
      acc_nxt_s = clamp_acc(sum_s);
      ovf_nxt_s = ovf_r | acc_clamped(sum_s);
    end
  end

  // S3: accumulator state; bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      ovf_r     <= 1'b0;
      s3_fire_r <= 1'b0;
    end else begin
      s3_fire_r <= s2_valid_r & s2_last_r;
      if (s2_valid_r) begin
        acc_r <= acc_nxt_s;
        ovf_r <= ovf_nxt_s;
      end
    end
  end

  // Round half up and arithmetic shift at ACC_W+1 bits so the bias cannot wrap.
  assign acc_ext_s = {acc_r[ACC_W-1], acc_r};
  if (SHIFT > 0) begin : g_round
    localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    logic signed [ACC_W:0] biased_s;
    assign biased_s = acc_ext_s + HALF;
    assign r_s      = biased_s >>> SHIFT;
  end else begin : g_noround
    assign r_s = acc_ext_s;
  end

  // S4: result register, loaded only when a frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      acc_out_r   <= '0;
      sat_out_r   <= '0;
      overflow_r  <= 1'b0;
    end else begin
      out_valid_r <= s3_fire_r;
      if (s3_fire_r) begin
        acc_out_r  <= acc_r;
        sat_out_r  <= clamp_out(r_s);
        overflow_r <= ovf_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc_out_r;
  assign bus.sat_out   = sat_out_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, fully pipelined signed multiply-accumulate unit for the DSP datapath; the fabric-inferred successor to the single-shot MAC16 usage.
- Accumulates a stream of products framed by first/last markers. Emits the full-width sum plus a rounded, shifted, saturated DATA_W result at a fixed latency.
- Tolerates input bubbles and drives a sticky overflow flag.
- Sits between the sample buffers and the filter/gain stages.

Parameters:
- DATA_W, 16, signed width of a, b and sat_out
- ACC_W, 32, accumulator width; must satisfy ACC_W >= 2*DATA_W
- SHIFT, 15, right shift applied before saturation (Q-format scaling); range 0..ACC_W-1

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a/b/first/last qualify this cycle
- a  in  DATA_W  signed multiplicand
- b  in  DATA_W  signed multiplier
- first  in  1  product starts a new sum (discards any prior partial sum)
- last  in  1  product ends the sum; result emitted
- out_valid  out  1  single-cycle pulse; result ports valid
- acc_out  out  ACC_W  signed saturated full-precision sum
- sat_out  out  DATA_W  rounded, shifted, saturated sum
- overflow  out  1  sum saturated at least once in the emitted frame

Behaviour:
- Pipeline stages, each with its own valid/first/last sideband:
  - S1: register a, b, first, last.
  - S2: signed product, 2*DATA_W bits, registered.
  - S3: accumulate.
  - S4: output register.
- Latency: in_valid&&last at cycle N -> out_valid=1 at cycle N+4, for exactly one cycle. Throughput is 1 product per cycle; back-to-back frames need no idle cycles.
- Bubbles: in_valid=0 cycles propagate as invalid and leave the accumulator and overflow state unchanged.
- Accumulate rule for a valid S3 entry:
  - first=1: acc <= sext(prod), ovf <= 0.
  - first=0: acc <= sat(acc + sext(prod)), computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; ovf <= ovf | clamped.
- first and last in the same cycle: single-product frame, result = that product.
- Product without a preceding first after reset: accumulates onto acc=0.
- A valid entry with last=1 loads the S4 registers and pulses out_valid. The accumulator keeps its value; the next frame must assert first.
- Output formatting (S4):
  - acc_out = the new acc value.
  - SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits (round half up).
  - SHIFT=0: r = acc.
  - sat_out = r clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- overflow = ovf including the current product; it does not reflect output-stage clamping. Output-stage clamping is visible only as sat_out at a rail.
- out_valid=0 cycles: acc_out, sat_out and overflow hold their last values.
- Reset (any cycle, including mid-frame): all stage valids, out_valid, acc, acc_out, sat_out and overflow go to 0 on the next edge. In-flight products are dropped, with no out_valid for them. The first valid input after reset release is accepted normally.
- No backpressure: the downstream consumer must accept out_valid pulses.

Test Plan:
- DATA_W=16, SHIFT=0:
  - Stimulus: 4 consecutive valids, a={5,-3,100,7}, b={3,4,2,-1}, first on beat 0, last on beat 3.
  - Required: out_valid exactly 4 cycles after beat 3; acc_out=196, sat_out=196, overflow=0.
- Single-product frame:
  - Stimulus: a=5, b=3, first=last=1.
  - Required: acc_out=15 after 4 cycles.
  - Follow-up: second frame a=-2, b=7 immediately after. Required: acc_out=-14 on the next cycle (no carry-over).
- SHIFT=15:
  - Stimulus: a=b=16'h4000, first=last.
  - Required: acc_out=268435456, sat_out=8192.
  - Stimulus: a=16'h4000, b=16'h0001. Required: 16384 -> sat_out=1 (rounded up from 0.5).
- Saturation, ACC_W=32:
  - Stimulus: three beats of a=b=-32768 (2^30 each).
  - Required: acc_out=2147483647, overflow=1, sat_out=32767 at SHIFT=0 and at SHIFT=15.
  - Follow-up: next frame 1*1. Required: overflow=0.
- Bubbles: same operands as the 4-beat dot-product scenario, with in_valid=0 gaps of 1 and 3 cycles between beats. Required: acc_out=196, out_valid 4 cycles after the last beat.
- Reset mid-frame:
  - Stimulus: rst=1 one cycle after beat 2 of a 4-beat frame.
  - Required: no out_valid for that frame; all outputs 0 after the reset edge.
  - Follow-up: a fresh frame 6*7 after reset. Required: acc_out=42.
